// File: rtl/memory_gateway_burst_sim.sv
// Behavioural burst memory gateway: ap_* request handshake, fixed-latency read and
// write bursts over a 2^ADDR_WIDTH word array with wraparound addressing.
module memory_gateway_burst_sim #(
  parameter int    DATA_WIDTH    = 16,
  parameter int    ADDR_WIDTH    = 22,
  parameter int    READ_LATENCY  = 4,
  parameter int    WRITE_LATENCY = 4,
  parameter int    MAX_BURST     = 16,
  parameter string FILENAME      = "",
  localparam int   BW            = $clog2(MAX_BURST + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [63:0]           memory_pointer,
  input  logic [63:0]           addr,
  input  logic [BW-1:0]         burst_len,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] ap_return,
  output logic                  error
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0]         RD_LAST  = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0]         WR_LAST  = CW'(WRITE_LATENCY - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [BW-1:0]         MAX_LEN  = BW'(MAX_BURST);
  localparam logic [BW-1:0]         ONE_BEAT = BW'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         beats;
  logic [BW-1:0]         len_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  wen_q;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Memory sits outside the reset domain so a reset never disturbs its contents.
  assign mem_we = (state == S_XFER) && wen_q && wdata_valid;

  always_ff @(posedge clock) begin
    if (mem_we) mem[ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      beats       <= '0;
      len_q       <= '0;
      ptr         <= '0;
      wen_q       <= 1'b0;
      ap_return   <= '0;
      error       <= 1'b0;
      ap_done     <= 1'b0;
      ap_ready    <= 1'b0;
      ap_idle     <= 1'b1;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
    end else begin
      ap_done     <= 1'b0;
      ap_ready    <= 1'b0;
      ap_idle     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          ap_idle <= 1'b1;
          if (ap_start) begin
            ap_idle <= 1'b0;
            ptr     <= ADDR_WIDTH'(memory_pointer + addr);
            len_q   <= burst_len;
            wen_q   <= wen;
            cnt     <= '0;
            beats   <= '0;
            if (burst_len == '0 || burst_len > MAX_LEN) begin
              error    <= 1'b1;
              state    <= S_DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              error <= 1'b0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Outputs are registered, so the first read beat is fetched on the way into Xfer.
          if (cnt == (wen_q ? WR_LAST : RD_LAST)) begin
            state <= S_XFER;
            if (wen_q) begin
              wdata_ready <= 1'b1;
            end else begin
              rdata       <= mem[ptr];
              rdata_valid <= 1'b1;
              ptr         <= ptr + ONE_ADDR;
              beats       <= ONE_BEAT;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_XFER: begin
          if (wen_q) begin
            if (wdata_valid) begin
              ptr   <= ptr + ONE_ADDR;
              beats <= beats + ONE_BEAT;
              if (beats + ONE_BEAT == len_q) begin
                state    <= S_DONE;
                ap_done  <= 1'b1;
                ap_ready <= 1'b1;
              end else begin
                wdata_ready <= 1'b1;
              end
            end else begin
              wdata_ready <= 1'b1;
            end
          end else begin
            ap_return <= rdata;
            if (beats == len_q) begin
              state    <= S_DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              rdata       <= mem[ptr];
              rdata_valid <= 1'b1;
              ptr         <= ptr + ONE_ADDR;
              beats       <= beats + ONE_BEAT;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_gateway_burst_sim.sv
// Scoreboard bench for memory_gateway_burst_sim: expected beats and completions are
// queued at issue time from an address-keyed memory model and drained by a monitor.
module tb_memory_gateway_burst_sim;

  localparam int DW = 16;
  localparam int AW = 22;
  localparam int RL = 4;
  localparam int WL = 4;
  localparam int MB = 16;
  localparam int BW = $clog2(MB + 1);
  localparam longint DEPTH = longint'(1) << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [63:0]   memory_pointer = '0;
  logic [63:0]   addr = '0;
  logic [BW-1:0] burst_len = '0;
  logic          wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic [DW-1:0] ap_return;
  logic          error;

  memory_gateway_burst_sim dut (
    .clock(clock), .reset_n(reset_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .memory_pointer(memory_pointer),
    .addr(addr), .burst_len(burst_len), .wen(wen), .wdata(wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .ap_return(ap_return), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            known;
    logic [DW-1:0] val;
  } rd_exp_t;

  typedef struct {
    bit            err;
    bit            ret_known;
    logic [DW-1:0] ret;
  } done_exp_t;

  rd_exp_t       rd_q[$];
  done_exp_t     done_q[$];
  logic [DW-1:0] model_mem [longint];
  bit            ret_known = 1'b1;
  logic [DW-1:0] model_ret = '0;
  logic [DW-1:0] wr_data[$];
  int            checks = 0;
  int            failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    checks++;
    failures++;
    $display("[TB] FAIL %s %s", name, detail);
  endtask

  // Monitor: every presented beat or completion is matched against the scoreboard.
  rd_exp_t   mon_rd;
  done_exp_t mon_done;
  always @(negedge clock) begin
    if (rdata_valid) begin
      if (rd_q.size() == 0) reportFail("unexpected_rdata_valid", $sformatf("rdata=0x%0h", rdata));
      else begin
        mon_rd = rd_q.pop_front();
        if (mon_rd.known) checkOutput("rdata", 64'(rdata), 64'(mon_rd.val));
      end
    end else begin
      checkOutput("rdata_zero_when_invalid", 64'(rdata), 64'd0);
    end
    if (ap_done) begin
      checkOutput("ap_ready_with_done", 64'(ap_ready), 64'd1);
      if (done_q.size() == 0) reportFail("unexpected_ap_done", $sformatf("error=%0d", error));
      else begin
        mon_done = done_q.pop_front();
        checkOutput("error_at_done", 64'(error), 64'(mon_done.err));
        if (mon_done.ret_known) checkOutput("ap_return_at_done", 64'(ap_return), 64'(mon_done.ret));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ap_idle"}, 64'(ap_idle), 64'd1);
    checkOutput({tag, "_ap_done"}, 64'(ap_done), 64'd0);
    checkOutput({tag, "_ap_ready"}, 64'(ap_ready), 64'd0);
    checkOutput({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
    checkOutput({tag, "_wdata_ready"}, 64'(wdata_ready), 64'd0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
    checkOutput({tag, "_ap_return"}, 64'(ap_return), 64'd0);
  endtask

  // Issues one request and drives its write beats; abort_after>0 resets mid-burst.
  task automatic applyStimulus(input logic [63:0] mp, input logic [63:0] ad, input int len,
                               input bit w, input int abort_after, input int gap_mode);
    longint    start, a;
    int        k, first_k, done_k, beat, target;
    bit        legal, gapped;
    rd_exp_t   re;
    done_exp_t de;
    k = 0;
    while (!ap_idle && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (!ap_idle) reportFail("idle_timeout", "gateway never returned to Idle");
    start = longint'((mp + ad) % 64'(DEPTH));
    legal = (len >= 1) && (len <= MB);
    memory_pointer = mp;
    addr = ad;
    burst_len = BW'(len);
    wen = w;
    ap_start = 1'b1;
    if (!legal) begin
      de = '{1'b1, ret_known, model_ret};
      done_q.push_back(de);
    end else if (!w) begin
      for (int i = 0; i < len; i++) begin
        a = (start + longint'(i)) % DEPTH;
        re.known = model_mem.exists(a);
        re.val = re.known ? model_mem[a] : '0;
        rd_q.push_back(re);
        ret_known = re.known;
        model_ret = re.val;
      end
      de = '{1'b0, ret_known, model_ret};
      done_q.push_back(de);
    end else if (abort_after == 0) begin
      de = '{1'b0, ret_known, model_ret};
      done_q.push_back(de);
    end
    @(negedge clock);
    ap_start = 1'b0;
    k = 1;
    if (!legal) begin
      checkOutput("illegal_done_next_cycle", 64'(ap_done), 64'd1);
      checkOutput("illegal_no_wdata_ready", 64'(wdata_ready), 64'd0);
    end else if (!w) begin
      first_k = -1;
      done_k = -1;
      while (k < 200) begin
        if (rdata_valid && first_k < 0) first_k = k;
        if (ap_done) begin
          done_k = k;
          break;
        end
        @(negedge clock);
        k++;
      end
      checkOutput("read_first_beat_cycle", 64'(first_k), 64'(RL + 1));
      checkOutput("read_done_cycle", 64'(done_k), 64'(RL + len + 1));
    end else begin
      beat = 0;
      gapped = 1'b0;
      target = (abort_after > 0) ? abort_after : len;
      while (beat < target && k < 500) begin
        if (wdata_ready) begin
          if ((gap_mode == 1 && $urandom_range(0, 3) == 0) || (gap_mode == 2 && beat == 1 && !gapped)) begin
            gapped = 1'b1;
            wdata_valid = 1'b0;
            wdata = DW'($urandom);
          end else begin
            wdata_valid = 1'b1;
            wdata = wr_data[beat];
            model_mem[(start + longint'(beat)) % DEPTH] = wr_data[beat];
            beat++;
          end
        end else begin
          wdata_valid = 1'($urandom_range(0, 1));
          wdata = DW'($urandom);
        end
        @(negedge clock);
        k++;
      end
      wdata_valid = 1'b0;
      if (beat < target) reportFail("write_beat_timeout", $sformatf("accepted=%0d of %0d", beat, target));
      if (abort_after > 0) begin
        reset_n = 1'b0;
        #1;
        checkResetValues("midburst_reset");
        ret_known = 1'b1;
        model_ret = '0;
        @(negedge clock);
        reset_n = 1'b1;
      end else begin
        checkOutput("write_done_after_last_beat", 64'(ap_done), 64'd1);
      end
    end
  endtask

  task automatic loadData(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    wr_data = {d0, d1, d2, d3};
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint     t;
    logic [63:0] mp, ad;
    int         len, r;
    bit         w;

    #1 reset_n = 1'b0;
    #1 checkResetValues("power_on_reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Basic read burst and its latency.
    loadData(16'd1, 16'd2, 16'd3, 16'd4);
    applyStimulus(64'h10, 64'h0, 4, 1'b1, 0, 0);
    applyStimulus(64'h10, 64'h0, 4, 1'b0, 0, 0);

    // Write with a one-cycle valid gap, then read back.
    loadData(16'hA, 16'hB, 16'hC, 16'h0);
    applyStimulus(64'h100, 64'h0, 3, 1'b1, 0, 2);
    applyStimulus(64'h0, 64'h100, 3, 1'b0, 0, 0);

    // Pointer wrap at the top of memory.
    loadData(16'd5, 16'd6, 16'd7, 16'd8);
    applyStimulus(64'(DEPTH - 2), 64'h0, 4, 1'b1, 0, 0);
    applyStimulus(64'(DEPTH - 2), 64'h0, 4, 1'b0, 0, 0);
    applyStimulus(64'h0, 64'h0, 2, 1'b0, 0, 0);

    // Illegal lengths leave memory untouched.
    loadData(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    applyStimulus(64'h10, 64'h0, 0, 1'b0, 0, 0);
    applyStimulus(64'h10, 64'h0, MB + 1, 1'b1, 0, 0);
    applyStimulus(64'h10, 64'h0, 0, 1'b1, 0, 0);
    applyStimulus(64'h10, 64'h0, 4, 1'b0, 0, 0);

    // Reset after two of four write beats.
    loadData(16'h11, 16'h12, 16'h13, 16'h14);
    applyStimulus(64'h200, 64'h0, 4, 1'b1, 0, 0);
    loadData(16'hE1, 16'hE2, 16'hE3, 16'hE4);
    applyStimulus(64'h200, 64'h0, 4, 1'b1, 2, 0);
    applyStimulus(64'h200, 64'h0, 4, 1'b0, 0, 0);

    // ap_start held high: exactly one request per Idle visit.
    while (!ap_idle) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back('{1'b1, 16'd3});
      done_q.push_back('{1'b0, 1'b1, 16'd3});
    end
    ret_known = 1'b1;
    model_ret = 16'd3;
    memory_pointer = 64'h10;
    addr = 64'h2;
    burst_len = BW'(1);
    wen = 1'b0;
    ap_start = 1'b1;
    repeat (2 * (RL + 3) + 1) @(negedge clock);
    ap_start = 1'b0;
    repeat (RL + 4) @(negedge clock);
    checkOutput("back_to_back_reads_drained", 64'(rd_q.size()), 64'd0);
    checkOutput("back_to_back_dones_drained", 64'(done_q.size()), 64'd0);

    // Randomised traffic in a window straddling the wrap point.
    for (int b = 0; b < 5; b++) begin
      wr_data.delete();
      for (int i = 0; i < 16; i++) wr_data.push_back(DW'($urandom));
      applyStimulus(64'(DEPTH - 40 + 16 * b), 64'h0, 16, 1'b1, 0, 1);
    end
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? MB + 1 : (1 << BW) - 1);
      else len = $urandom_range(1, MB);
      w = 1'($urandom_range(0, 1));
      t = (DEPTH - 40 + longint'($urandom_range(0, 64))) % DEPTH;
      mp = {$urandom, $urandom};
      ad = 64'(t) - mp + (64'($urandom_range(0, 7)) << AW);
      wr_data.delete();
      for (int i = 0; i < MB; i++) wr_data.push_back(DW'($urandom));
      applyStimulus(mp, ad, len, w, 0, 1);
    end

    repeat (3) @(negedge clock);
    checkOutput("final_read_queue_empty", 64'(rd_q.size()), 64'd0);
    checkOutput("final_done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_gateway_burst_sim.md
MEMORY_GATEWAY_BURST_SIM -- requirements
Module: memory_gateway_burst_sim

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 22, word-address bits; depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 4, wait cycles before first read beat; legal range >= 1.
REQ-004 SHALL have parameter WRITE_LATENCY, default 4, wait cycles before first write beat; legal range >= 1.
REQ-005 SHALL have parameter MAX_BURST, default 16, maximum beats per request; BW = clog2(MAX_BURST+1).
REQ-006 SHALL have parameter FILENAME, default "", binary-format image loaded into memory at time zero when non-empty; contents undefined when empty.
REQ-007 Ports, in order: clock in 1 (sole clock); reset_n in 1 (asynchronous, active-low).
REQ-008 ap_start in 1 request strobe; ap_done out 1; ap_idle out 1; ap_ready out 1.
REQ-009 memory_pointer in 64 base word offset; addr in 64 word offset; burst_len in BW beat count; wen in 1 (1 = write burst).
REQ-010 wdata in DATA_WIDTH; wdata_valid in 1; wdata_ready out 1.
REQ-011 rdata out DATA_WIDTH; rdata_valid out 1; ap_return out DATA_WIDTH last read beat; error out 1 illegal-length flag.

Function
REQ-012 States SHALL be Idle, Wait, Xfer, Done.
REQ-013 Idle: ap_idle=1; ap_start=1 SHALL capture start = (memory_pointer+addr) mod DEPTH, burst_len, wen, and move to Wait; ap_start=0 stays Idle.
REQ-014 burst_len==0 or >MAX_BURST at capture SHALL move Idle->Done directly, set error=1, with no memory access and no beats.
REQ-015 Wait SHALL last exactly LAT cycles (LAT = WRITE_LATENCY if wen else READ_LATENCY), counter 0..LAT-1, then Xfer.
REQ-016 Read Xfer: each cycle rdata=mem[ptr], rdata_valid=1, ap_return<=rdata, ptr and beat count advance; after burst_len beats -> Done; one beat per cycle, no stalls.
REQ-017 Write Xfer: wdata_ready=1; beat accepted only when wdata_valid=1, then mem[ptr]<=wdata at that edge, ptr and beat count advance; wdata_valid=0 stalls indefinitely; after burst_len accepted beats -> Done.
REQ-018 ptr SHALL wrap from DEPTH-1 to 0 within a burst.
REQ-019 Done: ap_done=ap_ready=1 for exactly one cycle, then Idle; error valid during Done, cleared on next Idle->Wait/Done capture.
REQ-020 Outside Xfer rdata=0, rdata_valid=0, wdata_ready=0; ap_idle=1 only in Idle.
REQ-021 ap_start outside Idle SHALL be ignored; a request whose Done cycle has ap_start high is not accepted until Idle.
REQ-022 ap_return SHALL hold last read beat until next read beat; write bursts leave it unchanged.
REQ-023 Read latency: start sampled at edge T -> first rdata_valid cycle T+READ_LATENCY+1, ap_done cycle T+READ_LATENCY+burst_len+1.
REQ-024 Read of a word written by an earlier completed request SHALL return the written value.

Reset
REQ-025 reset_n=0 SHALL immediately force Idle, counter/beat count/ptr=0, ap_return=0, error=0, ap_done=ap_ready=0, ap_idle=1, rdata_valid=wdata_ready=0.
REQ-026 Reset mid-burst SHALL abort; beats already written stay in memory; memory is never cleared or reloaded by reset.
REQ-027 First request SHALL be accepted on the first edge after reset_n deasserts.

Verification
REQ-028 Read, default params, FILENAME image mem[0x10..0x13]=1,2,3,4, memory_pointer=0x10, addr=0, burst_len=4, start at T -> rdata_valid T+5..T+8 with 1,2,3,4; ap_done T+9; ap_return=4.
REQ-029 Write burst_len=3 at 0x100, data 0xA,0xB,0xC with wdata_valid low one cycle between beats 1 and 2 -> Done one cycle after beat 3 accepted; read-back 0xA,0xB,0xC.
REQ-030 Wrap: pointer=DEPTH-2, burst_len=4 write 5,6,7,8 -> mem[DEPTH-2]=5, mem[DEPTH-1]=6, mem[0]=7, mem[1]=8.
REQ-031 burst_len=0 and burst_len=17 -> Done on next cycle, error=1, memory unchanged, no rdata_valid/wdata_ready.
REQ-032 reset_n pulsed low after 2 of 4 write beats -> outputs at reset values immediately; only first 2 words changed; next request served normally.
REQ-033 ap_start held high continuously with burst_len=1 read -> back-to-back requests, one ap_done per Idle->Done cycle, ignored in Wait/Xfer/Done.
